// File: rtl/rx_rev_wr_arb.sv
`timescale 1ns/1ps
// rx_rev_wr_arb
// Round-robin write arbiter that funnels timestamp frames from two requesters
// (req0 = RX parser, req1 = TX timestamp capture) into a single event-buffer
// write port. One frame is held at a time: it is captured on grant, stored
// once the buffer reports free space, and released when the buffer reports
// completion. A frame that waits too long is dropped and counted.
//
// Ports
//   clk, reset              : clock, asynchronous active-low reset
//   reqN_vaild/reqN_ready   : requester handshake (ready is a one-cycle accept)
//   reqN_addr/data1/data2   : frame type and the two timestamps
//   buf_wr_v_ready          : event buffer has free space
//   buf_wr_vaild            : one-cycle store strobe per frame
//   buf_wr_ready            : event buffer finished the store
//   buf_wr_addr/data1/data2 : registered copy of the held frame
//   grant_id                : source of the held frame (0 = req0, 1 = req1)
//   timeout_err             : one-cycle pulse when the held frame is dropped
//   drop_cnt                : saturating count of dropped frames
module rx_rev_wr_arb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 80,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_vaild,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data1,
  input  logic [DATA_W-1:0] req0_data2,
  input  logic              req1_vaild,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data1,
  input  logic [DATA_W-1:0] req1_data2,
  input  logic              buf_wr_v_ready,
  output logic              buf_wr_vaild,
  input  logic              buf_wr_ready,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data1,
  output logic [DATA_W-1:0] buf_wr_data2,
  output logic              grant_id,
  output logic              timeout_err,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    WAIT_DONE  = 2'd2
  } state_t;

  // The counter holds the number of cycles already spent waiting; the edge on
  // which it would reach TIMEOUT is the one where it currently equals
  // TIMEOUT-1. ">=" also covers WAIT_DONE entered on that very edge (the
  // store won the tie), so the frame still gets exactly one done-cycle.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_grant;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        grant_en;
  logic        grant_sel;
  logic        strobe_nxt;
  logic        drop_nxt;

  assign tmo_hit = (tmo_cnt >= TMO_LAST);

  // NOTE: every signal written here gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt  = IDLE;
    grant_en   = 1'b0;
    grant_sel  = 1'b0;
    strobe_nxt = 1'b0;
    drop_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req0_vaild || req1_vaild) begin
          grant_en = 1'b1;
          // On a tie the requester that did not win last time goes next;
          // otherwise the single active requester is taken.
          grant_sel = (req0_vaild && req1_vaild) ? ~last_grant : req1_vaild;
          state_nxt = WAIT_SPACE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_SPACE: begin
        if (buf_wr_v_ready) begin
          strobe_nxt = 1'b1;
          state_nxt  = WAIT_DONE;
        end else if (tmo_hit) begin
          drop_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_SPACE;
        end
      end
      WAIT_DONE: begin
        if (buf_wr_ready) begin
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          drop_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the frame registers are reset as well, because their reset value of
  // zero is visible on the output ports before the first capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      buf_wr_vaild <= 1'b0;
      timeout_err  <= 1'b0;
      drop_cnt     <= '0;
      buf_wr_addr  <= '0;
      buf_wr_data1 <= '0;
      buf_wr_data2 <= '0;
      grant_id     <= 1'b0;
      last_grant   <= 1'b1;
      tmo_cnt      <= '0;
    end else begin
      req0_ready   <= grant_en & ~grant_sel;
      req1_ready   <= grant_en &  grant_sel;
      buf_wr_vaild <= strobe_nxt;
      timeout_err  <= drop_nxt;

      if (grant_en) begin
        last_grant   <= grant_sel;
        grant_id     <= grant_sel;
        buf_wr_addr  <= grant_sel ? req1_addr  : req0_addr;
        buf_wr_data1 <= grant_sel ? req1_data1 : req0_data1;
        buf_wr_data2 <= grant_sel ? req1_data2 : req0_data2;
        tmo_cnt      <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (drop_nxt && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rx_rev_wr_arb.sv
`timescale 1ns/1ps
// tb_rx_rev_wr_arb
// Scoreboard bench: the stimulus process predicts each grant, store strobe and
// drop (with the cycle it must appear on) and queues it; an independent
// monitor pops and compares whenever the DUT presents a ready, strobe or
// timeout pulse.
module tb_rx_rev_wr_arb;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 80;
  localparam int TMO    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_vaild, req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data1, req0_data2;
  logic              req1_vaild, req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data1, req1_data2;
  logic              buf_wr_v_ready, buf_wr_vaild, buf_wr_ready;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data1, buf_wr_data2;
  logic              grant_id, timeout_err;
  logic [15:0]       drop_cnt;

  rx_rev_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0_vaild(req0_vaild), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data1(req0_data1), .req0_data2(req0_data2),
    .req1_vaild(req1_vaild), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data1(req1_data1), .req1_data2(req1_data2),
    .buf_wr_v_ready(buf_wr_v_ready), .buf_wr_vaild(buf_wr_vaild),
    .buf_wr_ready(buf_wr_ready), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data1(buf_wr_data1), .buf_wr_data2(buf_wr_data2),
    .grant_id(grant_id), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic              gid;
    int                cyc;
  } frame_t;
  typedef struct { logic gid; int cyc; } grant_t;
  typedef struct { logic [15:0] cnt; int cyc; } drop_t;

  frame_t frame_q[$];
  grant_t grant_q[$];
  drop_t  drop_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: pending frame per requester, last winner, drops.
  bit                last_g    = 1'b1;
  logic [15:0]       exp_drops = '0;
  bit                pend [2];
  logic [ADDR_W-1:0] p_addr [2];
  logic [DATA_W-1:0] p_d1 [2];
  logic [DATA_W-1:0] p_d2 [2];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic take_ready(input logic r);
    grant_t g;
    check("ready_expected", DATA_W'(grant_q.size() != 0), DATA_W'(1));
    if (grant_q.size() != 0) begin
      g = grant_q.pop_front();
      check("ready_src", DATA_W'(r), DATA_W'(g.gid));
      check("ready_cycle", DATA_W'(cyc), DATA_W'(g.cyc));
    end
  endtask

  task automatic take_strobe();
    frame_t f;
    check("strobe_expected", DATA_W'(frame_q.size() != 0), DATA_W'(1));
    if (frame_q.size() != 0) begin
      f = frame_q.pop_front();
      check("strobe_cycle", DATA_W'(cyc), DATA_W'(f.cyc));
      check("strobe_addr", DATA_W'(buf_wr_addr), DATA_W'(f.addr));
      check("strobe_data1", buf_wr_data1, f.d1);
      check("strobe_data2", buf_wr_data2, f.d2);
      check("strobe_grant_id", DATA_W'(grant_id), DATA_W'(f.gid));
    end
  endtask

  task automatic take_drop();
    drop_t d;
    check("drop_expected", DATA_W'(drop_q.size() != 0), DATA_W'(1));
    if (drop_q.size() != 0) begin
      d = drop_q.pop_front();
      check("drop_cycle", DATA_W'(cyc), DATA_W'(d.cyc));
      check("drop_cnt", DATA_W'(drop_cnt), DATA_W'(d.cnt));
    end
  endtask

  always @(negedge clk) begin
    if (req0_ready)   take_ready(1'b0);
    if (req1_ready)   take_ready(1'b1);
    if (buf_wr_vaild) take_strobe();
    if (timeout_err)  take_drop();
  end

  // ---------------- stimulus ----------------
  task automatic set_frame(input int r, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
    pend[r]   = 1'b1;
    p_addr[r] = a;
    p_d1[r]   = d1;
    p_d2[r]   = d2;
  endtask

  task automatic rand_frame(input int r);
    set_frame(r, ADDR_W'($urandom),
              DATA_W'({$urandom, $urandom, $urandom}),
              DATA_W'({$urandom, $urandom, $urandom}));
  endtask

  task automatic drive_reqs();
    req0_vaild = pend[0];  req0_addr = p_addr[0];
    req0_data1 = p_d1[0];  req0_data2 = p_d2[0];
    req1_vaild = pend[1];  req1_addr = p_addr[1];
    req1_data1 = p_d1[1];  req1_data2 = p_d2[1];
  endtask

  // One grant-to-release transaction, called at a negedge with the DUT idle.
  // sp: cycles buf_wr_v_ready stays low after the grant; dd: cycles between
  // the store strobe and buf_wr_ready. Edges are counted from the grant edge
  // (k = number of edges since grant): the strobe is issued on edge 1+sp if
  // that is within TMO; completion comes on edge 2+sp+dd. The wait limit is
  // TMO edges, extended to one done-edge when the store took the tie on TMO.
  task automatic do_round(input bit new0, input bit new1, input int sp, input int dd);
    bit g;
    int n, strobe_edge, done_edge, limit, end_j;
    bit strobe_exp, done_ok;
    if (new0 && !pend[0]) rand_frame(0);
    if (new1 && !pend[1]) rand_frame(1);
    if (!pend[0] && !pend[1]) rand_frame(0);
    drive_reqs();
    g = (pend[0] && pend[1]) ? ~last_g : pend[1];
    last_g = g;
    n = cyc + 1;
    grant_q.push_back('{gid: g, cyc: n});
    strobe_edge = 1 + sp;
    done_edge   = 2 + sp + dd;
    strobe_exp  = (strobe_edge <= TMO);
    limit       = strobe_exp ? ((strobe_edge + 1 > TMO) ? strobe_edge + 1 : TMO) : TMO;
    done_ok     = strobe_exp && (done_edge <= limit);
    if (strobe_exp)
      frame_q.push_back('{addr: p_addr[g], d1: p_d1[g], d2: p_d2[g], gid: g,
                          cyc: n + strobe_edge});
    if (!done_ok) begin
      if (exp_drops != 16'hFFFF) exp_drops = exp_drops + 16'd1;
      drop_q.push_back('{cnt: exp_drops, cyc: n + limit});
    end
    end_j = done_ok ? done_edge : limit;
    pend[g] = 1'b0;
    @(posedge clk);
    for (int j = 0; j < end_j; j++) begin
      @(negedge clk);
      if (j == 0) drive_reqs();
      buf_wr_v_ready = (j == sp);
      buf_wr_ready   = (j == done_edge - 1);
      @(posedge clk);
    end
    @(negedge clk);
    buf_wr_v_ready = 1'b0;
    buf_wr_ready   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req0_ready"}, DATA_W'(req0_ready), DATA_W'(0));
    check({tag, "_req1_ready"}, DATA_W'(req1_ready), DATA_W'(0));
    check({tag, "_buf_wr_vaild"}, DATA_W'(buf_wr_vaild), DATA_W'(0));
    check({tag, "_timeout_err"}, DATA_W'(timeout_err), DATA_W'(0));
    check({tag, "_drop_cnt"}, DATA_W'(drop_cnt), DATA_W'(0));
    check({tag, "_addr"}, DATA_W'(buf_wr_addr), DATA_W'(0));
    check({tag, "_data1"}, buf_wr_data1, DATA_W'(0));
    check({tag, "_data2"}, buf_wr_data2, DATA_W'(0));
    check({tag, "_grant_id"}, DATA_W'(grant_id), DATA_W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    p_addr[0] = '0; p_addr[1] = '0;
    p_d1[0] = '0; p_d1[1] = '0; p_d2[0] = '0; p_d2[1] = '0;
    drive_reqs();
    buf_wr_v_ready = 1'b0;
    buf_wr_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);

    // Both requesters always have a frame: grants alternate 0,1,... from 0.
    for (int i = 0; i < 8; i++) do_round(i < 7, 1'b1, 0, 0);

    // Single req0 frame, strobe one cycle after grant, done one cycle later.
    set_frame(0, 8'h02, 80'h1234, 80'h0);
    do_round(1'b0, 1'b0, 0, 1);

    // No free space: frame dropped TMO cycles after the grant.
    do_round(1'b1, 1'b0, 10, 0);

    // Completion / space on the same edge the counter hits the limit.
    do_round(1'b1, 1'b0, 0, TMO - 2);
    do_round(1'b0, 1'b1, TMO - 1, 0);
    do_round(1'b0, 1'b1, TMO - 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if (!pend[0] && !pend[1] && ($urandom_range(0, 3) == 0))
        repeat ($urandom_range(1, 3)) @(negedge clk);
      do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, TMO), $urandom_range(0, TMO - 1));
    end
    for (int i = 0; i < 2; i++) do_round(1'b0, 1'b0, 0, 0);

    // Reset while WAIT_DONE holds a stored frame.
    set_frame(0, 8'h5A, 80'hABCD, 80'h77);
    drive_reqs();
    n = cyc + 1;
    grant_q.push_back('{gid: ~last_g & 1'b0, cyc: n});
    last_g = 1'b0;
    frame_q.push_back('{addr: 8'h5A, d1: 80'hABCD, d2: 80'h77, gid: 1'b0, cyc: n + 1});
    pend[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_reqs();
    buf_wr_v_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    buf_wr_v_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_vals("midrst");
    last_g    = 1'b1;
    exp_drops = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_round(1'b1, 1'b1, 0, 0);
    do_round(1'b0, 1'b0, 0, 0);

    // Saturation of the drop counter.
    force dut.drop_cnt = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.drop_cnt;
    exp_drops = 16'hFFFE;
    @(negedge clk);
    check("drop_cnt_preload", DATA_W'(drop_cnt), DATA_W'(exp_drops));
    for (int i = 0; i < 3; i++) do_round(1'b1, 1'b0, TMO + 2, 0);

    repeat (4) @(negedge clk);
    check("drop_cnt_final", DATA_W'(drop_cnt), DATA_W'(exp_drops));
    check("grant_q_drained", DATA_W'(grant_q.size()), DATA_W'(0));
    check("frame_q_drained", DATA_W'(frame_q.size()), DATA_W'(0));
    check("drop_q_drained", DATA_W'(drop_q.size()), DATA_W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
